lut_engine: RTL and testbench
=============================

# lut_engine

Parametrised, runtime-programmable truth-table evaluator for IN_W-bit to OUT_W-bit functions. It is the sequential successor to our fixed combinational truth-table circuits and evaluates the same function as the power-on table. Queries flow through a one-stage valid/ready pipeline, and individual table rows can be rewritten at runtime. A reload sequencer restores the power-on table.

## Interface
- IN_W, 5: query/address width; table depth is 2^IN_W rows.
- OUT_W, 2: output bits per row.
- INIT, {32'h102e19a7, 32'h6af7ceaa}: power-on table, OUT_W×2^IN_W bits, column-major. y[k] for input x equals INIT[k·2^IN_W + x].

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  query present.
- in_ready  out  1  query accepted on the edge when in_valid && in_ready.
- in_x  in  IN_W  query input.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_y  out  OUT_W  result, table[in_x] at the time of acceptance.
- cfg_we  in  1  row write strobe.
- cfg_addr  in  IN_W  row to write.
- cfg_data  in  OUT_W  new row value.
- cfg_reload  in  1  pulse that starts a reload of INIT.
- cfg_busy  out  1  high while a reload is in progress.

## Operation
- Table: 2^IN_W × OUT_W flops.
  - Async reset loads INIT directly; no reload sequence runs after reset.
- FSM states: IDLE and RELOAD.
  - IDLE → RELOAD when cfg_reload=1; the row counter is cleared to 0.
  - In RELOAD, each cycle writes INIT row[cnt] and increments cnt.
  - RELOAD → IDLE after row 2^IN_W−1 is written. The IN_W-bit counter wraps to 0; the wrap is the exit condition.
  - cfg_reload is ignored while in RELOAD.
- Row write: in IDLE, cfg_we writes cfg_data to row cfg_addr on the edge. cfg_we is ignored in RELOAD and is never stalled.
- Query pipeline:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - On acceptance, out_y <= table[in_x] and out_valid <= 1.
  - If out_valid && out_ready and no new acceptance, out_valid <= 0.
  - While out_valid && !out_ready, out_y and out_valid hold stable.
- Same-edge cfg_we and query to the same address: read-before-write. The query returns the old row; the new value is visible to queries accepted on later edges.
- Results already in the output register keep draining during RELOAD; only new acceptances are blocked.
- cfg_reload and cfg_we on the same IDLE edge: the write is performed and the FSM enters RELOAD, so the reload later overwrites that row with INIT.

## Timing
- Reset values: out_valid=0, out_y=0, cfg_busy=0, in_ready=1 combinationally after reset, state=IDLE, cnt=0, table=INIT.
- Query latency: 1 cycle, acceptance edge to out_valid.
- Throughput: 1 query per cycle while out_ready=1.
- cfg_busy:
  - Registered; equals (state==RELOAD).
  - Rises on the edge after cfg_reload is sampled.
  - Stays high exactly 2^IN_W cycles (32 at default).
- in_ready is combinational from out_ready and state. There is no combinational path from in_valid or in_x to any output.
- Reset asserted mid-RELOAD: the table returns to INIT immediately, state=IDLE, and any pending result is dropped (out_valid=0).

## Structure
- Package lut_engine_pkg:
  - state enum {IDLE, RELOAD};
  - function init_row(x) that extracts the OUT_W-bit INIT row for input x.
- Sub-module lut_engine_table:
  - owns the flop array, the async INIT reset, one write port (muxed between cfg and reload) and one combinational read port;
  - the FSM and handshake logic stay in the top level.

## Test plan
- Default INIT, out_ready=1, stream x=0,3,31 → out_y=2'b10, 2'b01, 2'b00 on consecutive cycles, each 1 cycle after acceptance.
- Backpressure: accept x=1, hold out_ready=0 for 3 cycles → out_y=2'b11 held stable and in_ready=0; release → a queued x=5 returns 2'b11 on the next cycle.
- Write cfg_addr=3, cfg_data=2'b10 with a same-edge query x=3 → returns 2'b01; a query x=3 one cycle later → returns 2'b10.
- Pulse cfg_reload after the above → cfg_busy high for exactly 32 cycles; in_ready=0 and cfg_we ignored throughout; then x=3 → 2'b01.
- Assert rst at reload cycle 10 → cfg_busy=0 and out_valid=0 immediately; afterwards x=3 → 2'b01 and x=31 → 2'b00.
- Random queries interleaved with random row writes against a reference model with read-before-write semantics, running 10k cycles with random out_ready → zero mismatches.

Source files
------------

// File: rtl/lut_engine_pkg.sv
// rtl/lut_engine_pkg.sv - shared types and INIT row extraction for lut_engine
package lut_engine_pkg;

  typedef enum logic {IDLE, RELOAD} state_t;

  // Upper bounds for the generic INIT helper; every instance must fit inside them.
  localparam int MAX_INIT_W = 4096;
  localparam int MAX_OUT_W  = 16;

  // INIT is column-major: bit k of row x sits at INIT[k*2^in_w + x].
  function automatic logic [MAX_OUT_W-1:0] init_row(input logic [MAX_INIT_W-1:0] init,
                                                    input int in_w, input int out_w,
                                                    input int x);
    logic [MAX_OUT_W-1:0]  r;
    logic [MAX_INIT_W-1:0] sh;
    r = '0;
    for (int k = 0; k < out_w; k++) begin
      sh = init >> (k * (1 << in_w) + x);
      r  = r | ({{(MAX_OUT_W-1){1'b0}}, sh[0]} << k);
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_engine_if.sv
// rtl/lut_engine_if.sv - query stream and row configuration bundle for lut_engine
interface lut_engine_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_y;
  logic             cfg_we;
  logic [IN_W-1:0]  cfg_addr;
  logic [OUT_W-1:0] cfg_data;
  logic             cfg_reload;
  logic             cfg_busy;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data, cfg_reload,
    input  in_ready, out_valid, out_y, cfg_busy
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data, cfg_reload,
    output in_ready, out_valid, out_y, cfg_busy
  );
endinterface

// File: rtl/lut_engine_table.sv
// rtl/lut_engine_table.sv - truth-table flop array with INIT reset, one write and one read port
module lut_engine_table
  import lut_engine_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter logic [OUT_W*(2**IN_W)-1:0] INIT = 64'h102e19a7_6af7ceaa
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IN_W-1:0]  waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rdata
);
  localparam int DEPTH = 1 << IN_W;
  localparam logic [MAX_INIT_W-1:0] INIT_EXT = MAX_INIT_W'(INIT);

  logic [OUT_W-1:0] rows [DEPTH];

  // Rows come up holding INIT straight out of reset; afterwards one row per edge may change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rows[i] <= OUT_W'(init_row(INIT_EXT, IN_W, OUT_W, i));
      end
    end else if (we) begin
      rows[waddr] <= wdata;
    end
  end

  // Read is combinational, so a same-edge write is not seen by the query sampled on that edge.
  always_comb begin
    rdata = rows[raddr];
  end

endmodule

// File: rtl/lut_engine.sv
// rtl/lut_engine.sv - runtime-programmable truth-table evaluator with one-stage query pipeline
module lut_engine
  import lut_engine_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter logic [OUT_W*(2**IN_W)-1:0] INIT = 64'h102e19a7_6af7ceaa
) (
  input  logic          clk,
  input  logic          rst,
  lut_engine_if.slave   bus
);
  localparam logic [MAX_INIT_W-1:0] INIT_EXT = MAX_INIT_W'(INIT);

  state_t           state, state_nxt;
  logic [IN_W-1:0]  cnt;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_y_q;
  logic             busy_q;
  logic             accept;
  logic             tbl_we;
  logic [IN_W-1:0]  tbl_waddr;
  logic [OUT_W-1:0] tbl_wdata;
  logic [OUT_W-1:0] tbl_rdata;

  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.cfg_busy  = busy_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // State register and busy flag; busy mirrors the next state so it is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RELOAD);
    end
  end

  // Reload starts on cfg_reload and ends when the row counter wraps after the last row.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cfg_reload) state_nxt = RELOAD;
      RELOAD:  if (cnt == {IN_W{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Row counter sits at 0 in IDLE so a reload always begins at row 0, and wraps to 0 on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == RELOAD) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Single table write port: reload owns it in RELOAD, cfg writes own it in IDLE.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = bus.cfg_addr;
    tbl_wdata = bus.cfg_data;
    if (state == RELOAD) begin
      tbl_we    = 1'b1;
      tbl_waddr = cnt;
      tbl_wdata = OUT_W'(init_row(INIT_EXT, IN_W, OUT_W, int'(cnt)));
    end else if (bus.cfg_we) begin
      tbl_we    = 1'b1;
    end
  end

  lut_engine_table #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .INIT  (INIT)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (tbl_wdata),
    .raddr (bus.in_x),
    .rdata (tbl_rdata)
  );

  // Output register: load on acceptance, clear once drained, hold while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_y_q     <= tbl_rdata;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_engine.sv
// tb/tb_lut_engine.sv - randomized and directed self-checking bench for lut_engine
module tb_lut_engine;
  localparam int IN_W  = 5;
  localparam int OUT_W = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  lut_engine #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .INIT  (64'h102e19a7_6af7ceaa)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] init_v = 64'h102e19a7_6af7ceaa;
  int mtab [DEPTH];
  bit m_valid;
  int m_y;
  int m_rl;

  function automatic int ref_init(int x);
    return int'((init_v >> x) & 64'd1) | (int'((init_v >> (DEPTH + x)) & 64'd1) << 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mtab[i] = ref_init(i);
    m_valid = 1'b0;
    m_y     = 0;
    m_rl    = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_y", 32'(bus.out_y), 32'(m_y));
    check("cfg_busy", 32'(bus.cfg_busy), 32'(m_rl > 0));
  endtask

  // One clock: check in_ready, step the reference model, then check registered outputs.
  task automatic cycle();
    bit ready;
    bit acc;
    #1;
    ready = (m_rl == 0) && (!m_valid || bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(ready));
    acc = bus.in_valid && ready;
    @(posedge clk);
    #1;
    if (acc) begin
      m_y     = mtab[bus.in_x];
      m_valid = 1'b1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    if (m_rl > 0) begin
      m_rl--;
      if (m_rl == 0) for (int i = 0; i < DEPTH; i++) mtab[i] = ref_init(i);
    end else begin
      if (bus.cfg_we) mtab[bus.cfg_addr] = int'(bus.cfg_data);
      if (bus.cfg_reload) m_rl = DEPTH;
    end
    check_outputs();
  endtask

  task automatic query(int x);
    bus.in_valid = 1'b1;
    bus.in_x     = IN_W'(x);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid   = 1'b0;
    bus.in_x       = '0;
    bus.out_ready  = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_reload = 1'b0;
    model_reset();

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_y", 32'(bus.out_y), 32'd0);
    check("rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Streaming at full rate from the power-on table.
    bus.out_ready = 1'b1;
    query(0);  check("x0", 32'(bus.out_y), 32'd2);
    query(3);  check("x3", 32'(bus.out_y), 32'd1);
    query(31); check("x31", 32'(bus.out_y), 32'd0);
    cycle();

    // Backpressure holds the result and blocks new queries.
    query(1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 5'd5;
    repeat (3) begin
      cycle();
      check("bp_hold_y", 32'(bus.out_y), 32'd3);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_x5", 32'(bus.out_y), 32'd3);
    bus.in_valid = 1'b0;
    cycle();

    // Same-edge write and query: read-before-write.
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'd3;
    bus.cfg_data = 2'b10;
    query(3);
    check("rbw_old", 32'(bus.out_y), 32'd1);
    bus.cfg_we = 1'b0;
    query(3);
    check("rbw_new", 32'(bus.out_y), 32'd2);
    cycle();

    // Reload: busy for exactly DEPTH cycles, queries and writes locked out.
    bus.cfg_reload = 1'b1;
    cycle();
    bus.cfg_reload = 1'b0;
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 5'd0;
    bus.cfg_data   = 2'b01;
    bus.in_valid   = 1'b1;
    bus.in_x       = 5'd3;
    n = 0;
    while (bus.cfg_busy === 1'b1 && n < 100) begin
      n++;
      check("reload_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
    end
    check("reload_len", 32'(n), 32'd32);
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    query(3); check("reload_x3", 32'(bus.out_y), 32'd1);
    query(0); check("reload_x0", 32'(bus.out_y), 32'd2);
    cycle();

    // Reset in the middle of a reload with a stalled result pending.
    bus.out_ready  = 1'b0;
    bus.cfg_reload = 1'b1;
    query(0);
    bus.cfg_reload = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_busy", 32'(bus.cfg_busy), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    query(3);  check("post_rst_x3", 32'(bus.out_y), 32'd1);
    query(31); check("post_rst_x31", 32'(bus.out_y), 32'd0);

    // Random queries, writes, backpressure and occasional reloads.
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_x       = IN_W'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.cfg_we     = ($urandom_range(0, 4) == 0);
      bus.cfg_addr   = IN_W'($urandom);
      bus.cfg_data   = OUT_W'($urandom);
      bus.cfg_reload = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
